// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-add WIDTH x WIDTH multiplier with valid/ready handshakes
// Optional feature macro: SEQ_MULT_SIGNED_EN (adds sgn input for two's complement operands)
module seq_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
`ifdef SEQ_MULT_SIGNED_EN
   input  logic                 sgn,
`endif
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [2*WIDTH-1:0]   r_acc;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_neg;
   logic [2*WIDTH-1:0]   r_product;

   logic                 w_accept;
   logic                 w_last;
   logic [WIDTH-1:0]     w_a_load;
   logic [WIDTH-1:0]     w_b_load;
   logic                 w_neg;
   logic [2*WIDTH-1:0]   w_addend;
   logic [2*WIDTH-1:0]   w_acc_next;
   logic [2*WIDTH-1:0]   w_result;

   assign w_accept = (r_state == S_IDLE) && in_valid;
   assign w_last   = (r_state == S_BUSY) && (r_cnt == LAST_CNT);

`ifdef SEQ_MULT_SIGNED_EN
   // Signed mode multiplies magnitudes; the most negative value maps to
   // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit magnitude.
   logic w_a_neg;
   logic w_b_neg;
   assign w_a_neg  = sgn & a[WIDTH-1];
   assign w_b_neg  = sgn & b[WIDTH-1];
   assign w_a_load = w_a_neg ? -a : a;
   assign w_b_load = w_b_neg ? -b : b;
   assign w_neg    = w_a_neg ^ w_b_neg;
`else
   assign w_a_load = a;
   assign w_b_load = b;
   assign w_neg    = 1'b0;
`endif

   // The multiplicand is pre-shifted each step, so the current partial
   // product is always r_mcand gated by the multiplier's low bit.
   assign w_addend   = r_mplier[0] ? r_mcand : '0;
   assign w_acc_next = r_acc + w_addend;
   assign w_result   = r_neg ? -w_acc_next : w_acc_next;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: accept in IDLE, WIDTH steps in BUSY, hold in DONE until taken
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (in_valid)  w_next_state = S_BUSY;
         S_BUSY: if (w_last)    w_next_state = S_DONE;
         S_DONE: if (out_ready) w_next_state = S_IDLE;
         default:               w_next_state = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from the current state only
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (r_state)
         S_IDLE: in_ready = 1'b1;
         S_BUSY: busy = 1'b1;
         S_DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: in_ready = 1'b0;
      endcase
   end

   // Datapath: latch operands on accept, one shift-add per BUSY cycle, result on DONE entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_neg     <= 1'b0;
         r_product <= '0;
      end else if (w_accept) begin
         r_mcand  <= {{WIDTH{1'b0}}, w_a_load};
         r_mplier <= w_b_load;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_neg    <= w_neg;
      end else if (r_state == S_BUSY) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
         if (w_last) begin
            r_product <= w_result;
         end
      end
   end

   assign product = r_product;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - scoreboard bench for seq_multiplier (WIDTH=4 directed+random, WIDTH=8 random)
module tb_seq_multiplier;

   localparam int W4 = 4;
   localparam int W8 = 8;
`ifdef SEQ_MULT_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   // WIDTH=4 instance signals
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  a = '0;
   logic [3:0]  b = '0;
   logic        sgn = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  product;
   logic        busy;
   int          rdy4_mode = 0;

   // WIDTH=8 instance signals
   logic        rst8_n = 1'b0;
   logic        in_valid8 = 1'b0;
   logic        in_ready8;
   logic [7:0]  a8 = '0;
   logic [7:0]  b8 = '0;
   logic        out_valid8;
   logic        out_ready8 = 1'b1;
   logic [15:0] product8;
   logic        busy8;
   bit          done8 = 1'b0;

   logic [7:0]  exp4_q[$];
   logic [15:0] exp8_q[$];

   seq_multiplier #(.WIDTH(W4)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef SEQ_MULT_SIGNED_EN
      .sgn       (sgn),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   seq_multiplier #(.WIDTH(W8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst8_n),
`ifdef SEQ_MULT_SIGNED_EN
      .sgn       (1'b0),
`endif
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .a         (a8),
      .b         (b8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .product   (product8),
      .busy      (busy8)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Reference: plain integer product of the operand values, truncated to 2*w bits
   function automatic logic [63:0] ref_mul(input int w, input logic [63:0] av,
                                           input logic [63:0] bv, input bit s);
      longint sa;
      longint sb;
      longint mask;
      sa   = longint'(av);
      sb   = longint'(bv);
      mask = (longint'(1) << (2 * w)) - 1;
      if (s && av[w-1]) sa = sa - (longint'(1) << w);
      if (s && bv[w-1]) sb = sb - (longint'(1) << w);
      return 64'((sa * sb) & mask);
   endfunction

   always @(posedge clk) begin
      #1;
      case (rdy4_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'b0;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
      out_ready8 = ($urandom_range(0, 3) != 0);
   end

   // Monitor for the WIDTH=4 instance
   int          acc4_cyc = 0;
   bit          seen4 = 1'b0;
   bit          ready_chk4 = 1'b0;
   bit          prev_stall4 = 1'b0;
   logic [7:0]  prev_prod4 = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         seen4       = 1'b0;
         ready_chk4  = 1'b0;
         prev_stall4 = 1'b0;
      end else begin
         if (ready_chk4) begin
            check("in_ready_after_handshake", 64'(in_ready), 64'(1));
            ready_chk4 = 1'b0;
         end
         if (prev_stall4) begin
            check("stall_out_valid", 64'(out_valid), 64'(1));
            check("stall_product", 64'(product), 64'(prev_prod4));
            check("stall_in_ready", 64'(in_ready), 64'(0));
         end
         if (in_valid && in_ready) acc4_cyc = cyc;
         if (out_valid && !seen4) begin
            seen4 = 1'b1;
            check("latency4", 64'(cyc - acc4_cyc - 1), 64'(W4));
         end
         prev_stall4 = out_valid && !out_ready;
         prev_prod4  = product;
         if (out_valid && out_ready) begin
            if (exp4_q.size() == 0) fail_now("spurious_output4");
            else check("product4", 64'(product), 64'(exp4_q.pop_front()));
            seen4      = 1'b0;
            ready_chk4 = 1'b1;
         end
      end
   end

   // Monitor for the WIDTH=8 instance
   int acc8_cyc = 0;
   bit seen8 = 1'b0;
   always @(negedge clk) begin
      if (!rst8_n) begin
         seen8 = 1'b0;
      end else begin
         if (in_valid8 && in_ready8) acc8_cyc = cyc;
         if (out_valid8 && !seen8) begin
            seen8 = 1'b1;
            check("latency8", 64'(cyc - acc8_cyc - 1), 64'(W8));
         end
         if (out_valid8 && out_ready8) begin
            if (exp8_q.size() == 0) fail_now("spurious_output8");
            else check("product8", 64'(product8), 64'(exp8_q.pop_front()));
            seen8 = 1'b0;
         end
      end
   end

   // Called just after a rising edge; returns just after the accept edge
   task automatic send4(input logic [3:0] ta, input logic [3:0] tb, input bit ts);
      int  n;
      bit  s_eff;
      logic [63:0] e;
      n       = 0;
      s_eff   = ts & SIGNED_EN;
      a       = ta;
      b       = tb;
      sgn     = s_eff;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         fail_now("send4_timeout");
      end else begin
         e = ref_mul(W4, 64'(ta), 64'(tb), s_eff);
         exp4_q.push_back(e[7:0]);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = 4'($urandom);
      b        = 4'($urandom);
      sgn      = 1'($urandom) & SIGNED_EN;
   endtask

   task automatic send8(input logic [7:0] ta, input logic [7:0] tb);
      int  n;
      logic [63:0] e;
      n         = 0;
      a8        = ta;
      b8        = tb;
      in_valid8 = 1'b1;
      @(negedge clk);
      while (!in_ready8 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready8) begin
         fail_now("send8_timeout");
      end else begin
         e = ref_mul(W8, 64'(ta), 64'(tb), 1'b0);
         exp8_q.push_back(e[15:0]);
      end
      @(posedge clk);
      #1;
      in_valid8 = 1'b0;
      a8        = 8'($urandom);
      b8        = 8'($urandom);
   endtask

   task automatic wait_idle4();
      int n;
      n = 0;
      while ((exp4_q.size() != 0 || !in_ready) && n < 500) begin
         @(posedge clk);
         n++;
      end
      if (exp4_q.size() != 0 || !in_ready) fail_now("wait_idle4_timeout");
      @(posedge clk);
      #1;
   endtask

   // WIDTH=8 stream: 1000 random operations with random backpressure
   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      rst8_n = 1'b1;
      for (int i = 0; i < 1000; i++) send8(8'($urandom), 8'($urandom));
      n = 0;
      while (exp8_q.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      if (exp8_q.size() != 0) fail_now("drain8_timeout");
      done8 = 1'b1;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   // WIDTH=4 directed and random sequence, then summary
   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", 64'(in_ready), 64'(1));
      check("reset_out_valid", 64'(out_valid), 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_product", 64'(product), 64'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      send4(4'd15, 4'd15, 1'b0);
      check("busy_after_accept", 64'(busy), 64'(1));
      check("in_ready_in_busy", 64'(in_ready), 64'(0));
      wait_idle4();
      send4(4'd0, 4'd9, 1'b0);
      wait_idle4();
      send4(4'd9, 4'd0, 1'b0);
      wait_idle4();
      send4(4'd1, 4'd1, 1'b0);
      wait_idle4();

      rdy4_mode = 1;
      @(posedge clk);
      #1;
      send4(4'd6, 4'd7, 1'b0);
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!out_valid) fail_now("stall_wait_timeout");
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'($urandom);
         a        = 4'($urandom);
         b        = 4'($urandom);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("stall_product_value", 64'(product), 64'(8'h2A));
      rdy4_mode = 0;
      wait_idle4();

      send4(4'd6, 4'd5, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp4_q.delete();
      #1;
      check("abort_out_valid", 64'(out_valid), 64'(0));
      check("abort_in_ready", 64'(in_ready), 64'(1));
      check("abort_busy", 64'(busy), 64'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send4(4'd3, 4'd5, 1'b0);
      wait_idle4();

      send4(4'd8, 4'd8, 1'b1);
      wait_idle4();
      send4(4'd8, 4'd7, 1'b1);
      wait_idle4();
      send4(4'hF, 4'hF, 1'b0);
      wait_idle4();

      rdy4_mode = 2;
      for (int i = 0; i < 200; i++) send4(4'($urandom), 4'($urandom), 1'($urandom));
      rdy4_mode = 0;
      wait_idle4();

      n = 0;
      while (!done8 && n < 40000) begin
         @(posedge clk);
         n++;
      end
      if (!done8) fail_now("done8_timeout");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
